// File: rtl/uzorak_loader_pkg.sv
// Shared constants and state encoding for the sonar sample loader and Neural_net stage.
package uzorak_loader_pkg;

  localparam int unsigned N_FEAT   = 60;
  localparam int unsigned FEAT_W   = 16;
  localparam int unsigned UZORAK_W = N_FEAT * FEAT_W;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/uzorak_loader.sv
// Assembles N_FEAT streamed features into one uzorak vector, holds it until
// acknowledged, and flags frames whose in_last marker disagrees with the length.
module uzorak_loader #(
  parameter int unsigned N_FEAT = uzorak_loader_pkg::N_FEAT,
  parameter int unsigned FEAT_W = uzorak_loader_pkg::FEAT_W,
  parameter int unsigned CNT_W  = uzorak_loader_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [N_FEAT*FEAT_W-1:0] uzorak,
  output logic                     uzorak_valid,
  input  logic                     uzorak_ready,
  output logic [CNT_W-1:0]         feat_cnt,
  output logic                     err_len,
  output logic [15:0]              frame_cnt
);
  import uzorak_loader_pkg::*;

  localparam int unsigned UW = N_FEAT * FEAT_W;

  if ((2 ** CNT_W) < N_FEAT) begin : g_cnt_w_check
    $error("CNT_W too narrow for N_FEAT");
  end

  state_t state, state_nx;
  logic   xfer;
  logic   at_end;

  // in_ready depends on the state register alone, never on inputs.
  assign in_ready = (state == FILL);
  assign xfer     = in_valid & in_ready;
  assign at_end   = (feat_cnt == CNT_W'(N_FEAT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (xfer && at_end) state_nx = HOLD;
      HOLD:    if (uzorak_ready)   state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uzorak       <= '0;
      uzorak_valid <= 1'b0;
      feat_cnt     <= '0;
      err_len      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      err_len <= 1'b0;
      if (xfer) begin
        uzorak <= {uzorak[UW-FEAT_W-1:0], in_data};
        if (at_end) begin
          // A full-length frame is always delivered; a missing in_last only flags it.
          feat_cnt     <= '0;
          uzorak_valid <= 1'b1;
          frame_cnt    <= frame_cnt + 16'd1;
          err_len      <= ~in_last;
        end else if (in_last) begin
          feat_cnt <= '0;
          err_len  <= 1'b1;
        end else begin
          feat_cnt <= feat_cnt + 1'b1;
        end
      end else if (state == HOLD && uzorak_ready) begin
        uzorak_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uzorak_loader.sv
// Scoreboard bench for uzorak_loader: expected frames are queued as words are
// driven and compared when uzorak_valid rises.
module tb_uzorak_loader;
  import uzorak_loader_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [FEAT_W-1:0]   in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic                in_ready;
  logic [UZORAK_W-1:0] uzorak;
  logic                uzorak_valid;
  logic                uzorak_ready = 1'b0;
  logic [CNT_W-1:0]    feat_cnt;
  logic                err_len;
  logic [15:0]         frame_cnt;

  uzorak_loader #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .uzorak(uzorak),
    .uzorak_valid(uzorak_valid), .uzorak_ready(uzorak_ready),
    .feat_cnt(feat_cnt), .err_len(err_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned         n_checks = 0;
  int unsigned         n_errors = 0;
  logic [UZORAK_W-1:0] exp_q[$];
  logic [UZORAK_W-1:0] mdl = '0;
  int unsigned         mcnt = 0;
  int unsigned         exp_err = 0;
  int unsigned         obs_err = 0;
  logic [15:0]         exp_frames = '0;
  logic                prev_v = 1'b0;
  logic [UZORAK_W-1:0] held;

  task automatic chk(input string tag, input logic [UZORAK_W-1:0] got,
                     input logic [UZORAK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted word.
  task automatic model(input logic [FEAT_W-1:0] d, input logic l);
    mdl = {mdl[UZORAK_W-FEAT_W-1:0], d};
    if (mcnt == N_FEAT - 1) begin
      exp_q.push_back(mdl);
      exp_frames = exp_frames + 16'd1;
      if (!l) exp_err++;
      mcnt = 0;
    end else if (l) begin
      exp_err++;
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (err_len) obs_err++;
      if (uzorak_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("frame_data", uzorak, exp_q.pop_front());
          chk("frame_cnt", frame_cnt, exp_frames);
        end
      end
      prev_v = uzorak_valid;
    end
  end

  task automatic send(input logic [FEAT_W-1:0] d, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(d, l);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack(input int unsigned dly);
    int unsigned n = 0;
    while (!uzorak_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!uzorak_valid) begin
      chk("valid_timeout", uzorak_valid, 1);
      return;
    end
    repeat (dly) @(negedge clk);
    uzorak_ready = 1'b1;
    @(negedge clk);
    uzorak_ready = 1'b0;
    chk("ack_valid_low", uzorak_valid, 0);
    chk("ack_in_ready", in_ready, 1);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    uzorak_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    mdl        = '0;
    mcnt       = 0;
    exp_err    = 0;
    obs_err    = 0;
    exp_frames = '0;
    exp_q.delete();
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_uzorak", uzorak, 0);
    chk("rst_valid", uzorak_valid, 0);
    chk("rst_feat_cnt", feat_cnt, 0);
    chk("rst_err", err_len, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    do_reset();

    // Basic frame
    for (int i = 0; i < 59; i++) send(16'(i), 1'b0);
    chk("basic_feat_cnt59", feat_cnt, 59);
    chk("basic_no_early_valid", uzorak_valid, 0);
    send(16'h003B, 1'b1);
    chk("basic_valid", uzorak_valid, 1);
    chk("basic_first", uzorak[959:944], 16'h0000);
    chk("basic_last", uzorak[15:0], 16'h003B);
    chk("basic_frame_cnt", frame_cnt, 1);
    chk("basic_feat_cnt0", feat_cnt, 0);
    chk("basic_in_ready_hold", in_ready, 0);
    #1 chk("basic_no_err", obs_err, exp_err);

    // Backpressure in HOLD
    held     = uzorak;
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_frozen", uzorak, held);
      chk("bp_valid", uzorak_valid, 1);
    end
    uzorak_ready = 1'b1;
    @(negedge clk);
    uzorak_ready = 1'b0;
    chk("bp_ack_in_ready", in_ready, 1);
    chk("bp_ack_valid", uzorak_valid, 0);
    chk("bp_no_bypass", feat_cnt, 0);
    send(16'hAAAA, 1'b0);
    chk("bp_accepted", feat_cnt, 1);
    for (int i = 1; i < 60; i++) send(16'(16'h0200 + i), i == 59);
    chk("bp_feat0", uzorak[959:944], 16'hAAAA);
    chk("bp_frame_cnt", frame_cnt, 2);
    ack(0);

    // Short frame followed by a good one
    do_reset();
    for (int i = 0; i < 20; i++) send(16'(16'h0100 + i), i == 19);
    chk("short_err_pulse", err_len, 1);
    chk("short_feat_cnt", feat_cnt, 0);
    chk("short_no_valid", uzorak_valid, 0);
    @(negedge clk);
    chk("short_err_one_cycle", err_len, 0);
    for (int i = 0; i < 60; i++) send(16'(16'h0300 + i), i == 59);
    chk("short_next_valid", uzorak_valid, 1);
    chk("short_next_frame_cnt", frame_cnt, 1);
    #1 chk("short_err_count", obs_err, exp_err);
    ack(2);

    // Untagged frame
    do_reset();
    for (int i = 0; i < 60; i++) send(16'(16'h0400 + i), 1'b0);
    chk("untag_valid", uzorak_valid, 1);
    chk("untag_err", err_len, 1);
    chk("untag_frame_cnt", frame_cnt, 1);
    ack(1);
    send(16'h0777, 1'b0);
    chk("untag_next_frame", feat_cnt, 1);
    #1 chk("untag_err_count", obs_err, exp_err);

    // Asynchronous reset mid-frame
    do_reset();
    for (int i = 0; i < 30; i++) send(16'(16'h0500 + i), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("amid_uzorak", uzorak, 0);
    chk("amid_feat_cnt", feat_cnt, 0);
    chk("amid_valid", uzorak_valid, 0);
    chk("amid_in_ready", in_ready, 1);
    @(negedge clk);
    rst        = 1'b0;
    mdl        = '0;
    mcnt       = 0;
    exp_err    = 0;
    obs_err    = 0;
    exp_frames = '0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) send(16'(16'h0600 + i), i == 59);
    chk("amid_first", uzorak[959:944], 16'h0600);
    chk("amid_frame_cnt", frame_cnt, 1);
    ack(0);

    // Stalled input with random acknowledge delay
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(16'($urandom), i == 59);
      end
      ack($urandom_range(0, 5));
    end
    chk("stall_frame_cnt", frame_cnt, 3);
    #1 chk("stall_err_count", obs_err, exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uzorak_loader.md
Name: uzorak_loader

Overview:
- Upstream feeder for the sonar mine/rock Neural_net stage.
- Accepts one 16-bit feature per transfer over a valid/ready stream and assembles 60 features into the 960-bit uzorak vector.
- Holds the assembled vector stable with uzorak_valid until the consumer acknowledges it.
- Detects frame-length errors against an in_last marker.

Parameters:
- N_FEAT, 60, features per sample
- FEAT_W, 16, bits per feature (hex fixed-point, same format as the Neural_net inputs)
- CNT_W, 6, feature counter width; must satisfy 2**CNT_W >= N_FEAT

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  FEAT_W  feature word
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final feature of a sample; qualified by in_valid
- in_ready  out  1  loader can accept a word this cycle
- uzorak  out  N_FEAT*FEAT_W  assembled sample; feature 0 in bits [959:944], feature 59 in bits [15:0]
- uzorak_valid  out  1  uzorak complete and stable
- uzorak_ready  in  1  consumer takes the sample this cycle
- feat_cnt  out  CNT_W  features accepted in the current frame
- err_len  out  1  one-cycle pulse on a frame-length error
- frame_cnt  out  16  completed frames delivered; wraps at 65535 -> 0

Behaviour:
- Reset: clk and rst as named above; reset is asynchronous, active-high.
- Reset values: state=FILL, uzorak=0, uzorak_valid=0, feat_cnt=0, err_len=0, frame_cnt=0. in_ready=1 after reset deasserts.
- Reset asserted mid-frame or in HOLD discards all content immediately. No partial frame survives.
- States: FILL and HOLD.
- FILL behaviour:
  - in_ready=1.
  - A transfer occurs on in_valid & in_ready at a rising edge.
  - On transfer, uzorak <= {uzorak[N*W-W-1:0], in_data}, i.e. shift left one feature and insert at the LSB end. After 60 transfers, the first word sits at the MSBs.
  - feat_cnt increments by 1 per transfer.
- FILL, transfer with feat_cnt==N_FEAT-1: go to HOLD, uzorak_valid=1 from the next cycle, feat_cnt->0, frame_cnt+1. Latency is 1 cycle from the 60th transfer edge to uzorak_valid high.
- FILL, transfer with in_last=1 and feat_cnt<N_FEAT-1 (short frame):
  - Drop the frame: feat_cnt->0, uzorak keeps stale bits, no valid.
  - err_len pulses 1 cycle.
- FILL, 60th transfer with in_last=0 (long or untagged frame):
  - The frame is still delivered.
  - err_len pulses 1 cycle.
  - Subsequent words start the next frame.
- HOLD behaviour:
  - in_ready=0 and uzorak is frozen.
  - On uzorak_ready=1 at an edge: go to FILL, uzorak_valid->0 next cycle, in_ready=1 next cycle.
  - No word is accepted in the same cycle as the acknowledge; there is no bypass. Minimum frame period is therefore 61 cycles.
- uzorak_ready while in FILL is ignored.
- in_valid while in HOLD is back-pressured. The source must hold in_data, in_valid and in_last stable until in_ready.
- in_data and in_last are ignored when in_valid=0.
- err_len and valid/frame events are mutually consistent within a cycle: the 60th word with in_last=0 gives both the valid transition and the err_len pulse.
- All outputs are registered except in_ready, which is decoded from the state register only and never from inputs.

Decomposition:
- Shared package: N_FEAT=60, FEAT_W=16, UZORAK_W=960, and the state encoding (FILL=1'b0, HOLD=1'b1). Neural_net and its bench use the same constants.
- No sub-module. Counter, shift register and 2-state FSM live in one module.

Test Plan:
- Basic frame:
  - Stimulus: after reset, stream words 16'h0000..16'h003B with in_last on the last, uzorak_ready held 0.
  - Required response: uzorak_valid rises 1 cycle after the 60th edge; uzorak[959:944]=16'h0000, uzorak[15:0]=16'h003B; frame_cnt=1; err_len never pulses.
- Backpressure:
  - Stimulus: in HOLD, keep in_valid=1 with 16'hAAAA for 10 cycles, then pulse uzorak_ready.
  - Required response: in_ready=0 and uzorak unchanged during the hold; the next cycle shows in_ready=1 and valid=0; 16'hAAAA becomes feature 0 of the next frame.
- Short frame:
  - Stimulus: 20 words with in_last on the 20th, then a correct 60-word frame.
  - Required response: err_len pulses once at the 20th word; no valid for the short frame; the second frame delivered correctly with frame_cnt=1.
- Untagged frame:
  - Stimulus: 60 words, in_last=0 throughout.
  - Required response: valid and err_len both asserted after the 60th edge; frame_cnt=1.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (between edges) after 30 words, release, then send 60 words.
  - Required response: outputs reach reset values immediately on rst; the first frame after release contains only post-reset words.
- Stalled input:
  - Stimulus: random in_valid gaps at 50% duty over 3 frames, random uzorak_ready delay 0-5 cycles.
  - Required response: every frame's uzorak matches the scoreboard; frame_cnt=3.
